wb_io_arbiter: RTL
==================

// Module: wb_io_arbiter
// PURPOSE
//  Shares the single Wishbone IO slave bus (wb_m2s_io_* / wb_s2m_io_*) of rv32i_soc
//  between NUM_MASTERS requesters: core data port (m0), JTAG debug module (m1), spare (m2+).
//  Arbitration is round-robin and held per transaction.
//  A bus watchdog terminates unacknowledged cycles with err so no master can hang the bus.
//  Sits between the masters and the IO address decoder, feeding UART/SPI/GPIO/PWM.
// PARAMETERS
//  NUM_MASTERS    2     number of requesting masters (2..4)
//  ADR_W          32    Wishbone address width
//  DAT_W          32    Wishbone data width; SEL width = DAT_W/8
//  TIMEOUT_CYCLES 255   cycles of stb with no ack/err before the watchdog fires (1..65535)
// PORTS
//  clock        in   1                   system clock
//  reset        in   1                   synchronous reset, active-high
//  m_adr_i      in   NUM_MASTERS*ADR_W   per-master address (master k at [k*ADR_W +: ADR_W])
//  m_dat_i      in   NUM_MASTERS*DAT_W   per-master write data
//  m_sel_i      in   NUM_MASTERS*SEL_W   per-master byte select
//  m_we_i       in   NUM_MASTERS         per-master write enable
//  m_cyc_i      in   NUM_MASTERS         per-master cycle (bus request)
//  m_stb_i      in   NUM_MASTERS         per-master strobe
//  m_dat_o      out  DAT_W               read data, broadcast to all masters
//  m_ack_o      out  NUM_MASTERS         ack, only to the granted master
//  m_err_o      out  NUM_MASTERS         err, only to the granted master
//  s_adr_o      out  ADR_W               to slave: address of granted master
//  s_dat_o      out  DAT_W               to slave: write data
//  s_sel_o      out  SEL_W               to slave: byte select
//  s_we_o       out  1                   to slave: write enable
//  s_cyc_o      out  1                   to slave: cycle
//  s_stb_o      out  1                   to slave: strobe
//  s_dat_i      in   DAT_W               from slave: read data
//  s_ack_i      in   1                   from slave: ack
//  s_err_i      in   1                   from slave: err
//  grant_o      out  NUM_MASTERS         one-hot current grant, 0 when idle
//  timeout_o    out  1                   one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, rr_ptr=0, wd_cnt=0; all s_* outputs 0, m_ack_o/m_err_o 0, timeout_o 0.
//  FSM states IDLE, GRANT, ABORT (registered):
//   IDLE : if any m_cyc_i, pick the first requester scanning from rr_ptr upward (mod NUM_MASTERS).
//          grant <= onehot(k); go GRANT. Request at edge N -> s_cyc_o high in cycle N+1.
//   GRANT: s_* = granted master's signals, gated with its cyc. s_ack_i/s_err_i route to that master.
//          Grant is held for as long as m_cyc_i[k] stays high (bursts and RMW are atomic).
//          When m_cyc_i[k] drops: grant <= 0, rr_ptr <= k+1 (wraps), go IDLE.
//          One mandatory idle cycle separates consecutive grants.
//   ABORT: entered when wd_cnt reaches TIMEOUT_CYCLES-1 with stb high and no ack/err.
//          In ABORT: s_cyc_o=s_stb_o=0, m_err_o[k]=1 and timeout_o=1 for exactly one cycle.
//          Next state GRANT if m_cyc_i[k] is still high, else IDLE with rr_ptr advanced.
//  Watchdog: wd_cnt clears on ack, err, or stb low. It increments each GRANT cycle with s_stb_o=1
//   and ack=err=0, and saturates at TIMEOUT_CYCLES-1.
//  Ack/err arriving in the same cycle the watchdog would fire: the slave response wins, no abort.
//  Ungranted masters see ack=err=0 regardless of their stb.
//  m_dat_o = s_dat_i, combinational, no added latency. Ack/err add 0 cycles of latency.
//  Simultaneous requests are resolved purely by rr_ptr; a master's cyc dropping in IDLE before
//   it is sampled is never granted.
//  reset asserted mid-transaction: the next edge forces IDLE and drops s_cyc_o/s_stb_o.
//   No ack is produced after reset.
//  Slave returning ack with stb low: ignored, never forwarded.
// STRUCTURE
//  Shared package wb_arb_pkg: arb_state_e {IDLE,GRANT,ABORT}, SEL_W function, DEFAULT_TIMEOUT const.
//  One sub-module: rr_priority_picker (NUM_MASTERS req + ptr -> one-hot grant, combinational).
//  FSM, watchdog counter, and output muxes live in wb_io_arbiter.
// TESTING
//  1 Single master: m0 writes 0xDEAD_BEEF to 0x2000_0000, slave acks 1 cycle later ->
//    s_* mirrors m0 from cycle N+1; m_ack_o=2'b01 for one cycle; grant_o returns to 0.
//  2 Contention: m0 and m1 raise cyc together after reset ->
//    m0 granted first, m1 granted 2 cycles after m0 cyc drops, then m0 again (strict alternation).
//  3 Locked burst: m1 holds cyc over 4 stb/ack beats while m0 requests ->
//    m0 stays ungranted until m1 cyc falls; m0 sees no ack.
//  4 Watchdog: TIMEOUT_CYCLES=8, slave never acks m0 read ->
//    after 8 stb cycles, m_err_o[0] and timeout_o pulse once and s_stb_o drops for 1 cycle.
//  5 Race: ack arrives on the cycle wd_cnt=7 (TIMEOUT_CYCLES=8) -> normal ack, timeout_o stays 0.
//  6 Reset mid-burst: assert reset while m1 stb high -> next cycle s_cyc_o=0, grant_o=0, rr_ptr=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone IO bus arbiter.
//   arb_state_e     : arbiter FSM states
//   DEFAULT_TIMEOUT : default watchdog limit in strobe cycles
//   sel_w()         : byte-select width for a given data width
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic int sel_w(input int dat_w);
    return dat_w / 8;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker (purely combinational).
// Scans the request vector starting at index ptr and wrapping modulo NUM_MASTERS;
// the first asserted request wins.
// Ports:
//   req : per-master request vector
//   ptr : index that has highest priority this round
//   gnt : one-hot winner, all zero when nobody requests
module rr_priority_picker #(
  parameter  int NUM_MASTERS = 2,
  localparam int PTR_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(ptr) + i) % NUM_MASTERS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_io_arbiter.sv
// Wishbone IO bus arbiter: shares one slave bus between NUM_MASTERS masters.
// Round-robin grant held for a whole cyc transaction, one idle cycle between
// grants, and a watchdog that terminates unanswered strobes with err.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   m_adr_i/m_dat_i/m_sel_i      : packed per-master address / write data / byte select
//   m_we_i/m_cyc_i/m_stb_i       : per-master write enable / cycle / strobe
//   m_dat_o                      : slave read data broadcast to all masters
//   m_ack_o/m_err_o              : per-master ack / err, only to the granted master
//   s_adr_o..s_stb_o             : slave-side request of the granted master
//   s_dat_i/s_ack_i/s_err_i      : slave response
//   grant_o                      : one-hot current grant (0 when idle)
//   timeout_o                    : one-cycle pulse when the watchdog fires
module wb_io_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 2,
  parameter  int ADR_W          = 32,
  parameter  int DAT_W          = 32,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  localparam int SEL_W          = sel_w(DAT_W),
  localparam int PTR_W          = $clog2(NUM_MASTERS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_MASTERS*ADR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DAT_W-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_W-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  output logic [DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [ADR_W-1:0]             s_adr_o,
  output logic [DAT_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]             s_sel_o,
  output logic                         s_we_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  input  logic [DAT_W-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         timeout_o
);

  // 16 bits covers the full 1..65535 timeout range.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt, pick;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_nxt, gidx, gidx_nxt, pick_idx, next_ptr;
  logic [15:0]            wd_cnt, wd_cnt_nxt;
  logic                   sel_cyc, sel_stb;

  rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req (m_cyc_i),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign next_ptr = (gidx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
  assign sel_cyc  = m_cyc_i[gidx];
  assign sel_stb  = m_stb_i[gidx];
  assign m_dat_o  = s_dat_i;
  assign grant_o  = grant;

  // Slave-side mux and response routing. Everything is gated by the granted
  // master's cyc so a dropped cyc releases the slave bus immediately.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    m_ack_o   = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;
    case (state)
      GRANT: begin
        if (sel_cyc) begin
          s_cyc_o = 1'b1;
          s_stb_o = sel_stb;
          s_adr_o = m_adr_i[gidx*ADR_W +: ADR_W];
          s_dat_o = m_dat_i[gidx*DAT_W +: DAT_W];
          s_sel_o = m_sel_i[gidx*SEL_W +: SEL_W];
          s_we_o  = m_we_i[gidx];
        end
        // A response without an active strobe is stray and is dropped.
        m_ack_o[gidx] = s_ack_i & s_stb_o;
        m_err_o[gidx] = s_err_i & s_stb_o;
      end
      ABORT: begin
        m_err_o[gidx] = 1'b1;
        timeout_o     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    gidx_nxt   = gidx;
    rr_ptr_nxt = rr_ptr;
    wd_cnt_nxt = wd_cnt;
    case (state)
      IDLE: begin
        wd_cnt_nxt = '0;
        if (|m_cyc_i) begin
          grant_nxt = pick;
          gidx_nxt  = pick_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!sel_cyc) begin
          grant_nxt  = '0;
          rr_ptr_nxt = next_ptr;
          wd_cnt_nxt = '0;
          state_nxt  = IDLE;
        end else if (!s_stb_o || s_ack_i || s_err_i) begin
          // A slave response on the last watchdog cycle still wins.
          wd_cnt_nxt = '0;
        end else if (wd_cnt == WD_LAST) begin
          wd_cnt_nxt = '0;
          state_nxt  = ABORT;
        end else begin
          wd_cnt_nxt = wd_cnt + 16'd1;
        end
      end
      ABORT: begin
        wd_cnt_nxt = '0;
        if (sel_cyc) begin
          state_nxt = GRANT;
        end else begin
          grant_nxt  = '0;
          rr_ptr_nxt = next_ptr;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      gidx   <= gidx_nxt;
      rr_ptr <= rr_ptr_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

endmodule
